mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 256, memory line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 64, cycles to wait for mem_ack_i before abort; 0 disables the watchdog.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have ports p0_enable_i / p1_enable_i, input, 1 each, request held high until that port's ack (p0 = dcache, p1 = icache).
REQ-007 SHALL have ports p0_write_i / p1_write_i, input, 1 each, 1 = line write, 0 = line read.
REQ-008 SHALL have ports p0_addr_i / p1_addr_i, input, ADDR_W each, line-aligned address.
REQ-009 SHALL have ports p0_data_i / p1_data_i, input, DATA_W each, write line.
REQ-010 SHALL have ports p0_ack_o / p1_ack_o, output, 1 each, one-cycle completion pulse.
REQ-011 SHALL have ports p0_data_o / p1_data_o, output, DATA_W each, read line, valid while that port's ack is high.
REQ-012 SHALL have ports mem_enable_o, output, 1; mem_write_o, output, 1; mem_addr_o, output, ADDR_W; mem_data_o, output, DATA_W: the data-memory request.
REQ-013 SHALL have ports mem_ack_i, input, 1, and mem_data_i, input, DATA_W: the data-memory response.
REQ-014 SHALL have port err_o, output, 1, sticky timeout flag.

Function
REQ-015 SHALL implement states IDLE, BUSY and DONE.
REQ-016 In IDLE with any p*_enable_i high, SHALL grant one port, register its write/addr/data into mem_write_o/mem_addr_o/mem_data_o, set mem_enable_o=1 and go to BUSY at the same edge.
REQ-017 With only one port requesting, SHALL grant that port.
REQ-018 With both ports requesting in the same cycle, SHALL grant the port not granted last (round-robin), then record the grant in last_grant.
REQ-019 In BUSY, SHALL hold the mem_* outputs constant and ignore changes on the p*_ inputs.
REQ-020 In BUSY with mem_ack_i=1, SHALL combinationally drive the granted port's ack_o=1 and data_o=mem_data_i in the same cycle, then clear mem_enable_o and go to DONE.
REQ-021 The non-granted port's ack_o SHALL remain 0 at all times, including a mem_ack_i pulse that arrives outside BUSY.
REQ-022 DONE SHALL last exactly one cycle, grant nothing, then return to IDLE; this gives the requester time to drop its enable and prevents a stale re-grant.
REQ-023 Minimum request cycle SHALL be: grant edge, then ack cycle, then DONE, then IDLE; back-to-back grants are therefore at best 1 idle cycle apart.
REQ-024 p*_data_o SHALL be 0 whenever the corresponding ack_o is 0.
REQ-025 With TIMEOUT>0, a wait counter SHALL clear on grant and increment each BUSY cycle without mem_ack_i.
REQ-026 When the wait counter reaches TIMEOUT-1 without ack, SHALL set err_o=1, clear mem_enable_o, issue no ack, and go to DONE.
REQ-027 An ack in the same cycle as the timeout SHALL win: normal completion, err_o unchanged.
REQ-028 err_o SHALL clear only on reset.
REQ-029 A request withdrawn before grant SHALL be silently dropped.
REQ-030 A request withdrawn while in BUSY SHALL still complete on memory, with the ack pulse still driven.

Reset
REQ-031 On rst_i=1, SHALL immediately force: state=IDLE, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p0_ack_o=0, p1_ack_o=0, err_o=0, wait counter=0, last_grant=p1 (so p0 wins the first tie).
REQ-032 Reset asserted during BUSY SHALL abandon the transfer with no ack; after release, arbitration restarts from IDLE.

Verification
REQ-033 Single read: p0 read, addr 0x0000_0400; mem acks after 10 cycles with a pattern line -> mem_addr_o=0x400, mem_write_o=0, p0_ack_o high 1 cycle carrying that line, p1_ack_o=0.
REQ-034 Tie: both ports enabled in the first cycle after reset -> p0 granted first; once p0 drops its enable, p1 granted after the DONE cycle; repeat the tie -> p0 granted before p1 again (alternation).
REQ-035 Write-back then refill: p0 write to 0x800 with data D, then read from 0xC00 -> memory sees write(0x800,D), then read(0xC00); p1_data_i changes during BUSY do not alter mem_data_o.
REQ-036 Timeout: TIMEOUT=8, no ack -> mem_enable_o drops 8 cycles after grant, err_o=1, no ack; a later request still completes normally and err_o stays 1.
REQ-037 Ack on the timeout cycle: TIMEOUT=8, ack on the 8th BUSY cycle -> normal completion, err_o=0.
REQ-038 Reset mid-BUSY: assert rst_i 3 cycles after grant -> all outputs 0 immediately, no ack; after release a new p1 request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: two cache request ports (p0 = dcache, p1 = icache)
// plus the shared data-memory request/response channel and the sticky error flag.
interface mem_arbiter_if #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 32
);
   logic              p0_enable_i;
   logic              p0_write_i;
   logic [ADDR_W-1:0] p0_addr_i;
   logic [DATA_W-1:0] p0_data_i;
   logic              p0_ack_o;
   logic [DATA_W-1:0] p0_data_o;

   logic              p1_enable_i;
   logic              p1_write_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic [DATA_W-1:0] p1_data_i;
   logic              p1_ack_o;
   logic [DATA_W-1:0] p1_data_o;

   logic              mem_enable_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_data_i;

   logic              err_o;

   // Arbiter side: takes cache requests and memory responses.
   modport slave (
      input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      input  mem_ack_i, mem_data_i,
      output p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output err_o
   );

   // Requester and memory side.
   modport master (
      output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
      output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
      output mem_ack_i, mem_data_i,
      input  p0_ack_o, p0_data_o, p1_ack_o, p1_data_o,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  err_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single line-wide data memory, with an
// optional ack watchdog that aborts a stuck transfer and raises a sticky error.
module mem_arbiter #(
   parameter int DATA_W  = 256,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit               WDOG_EN  = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t              state_r,      next_state_s;
   logic                grant_r,      grant_s;
   logic                last_grant_r, last_grant_s;
   logic [CNT_W-1:0]    wait_cnt_r,   wait_cnt_s;
   logic                err_r,        err_s;
   logic                mem_enable_r, mem_enable_s;
   logic                mem_write_r,  mem_write_s;
   logic [ADDR_W-1:0]   mem_addr_r,   mem_addr_s;
   logic [DATA_W-1:0]   mem_data_r,   mem_data_s;

   logic                pick_s;
   logic                ack0_s;
   logic                ack1_s;

   // Arbitration choice: a tie goes to the port that did not win last time.
   always_comb begin
      pick_s = 1'b0;
      if (bus.p0_enable_i && bus.p1_enable_i) begin
         pick_s = ~last_grant_r;
      end else if (bus.p0_enable_i) begin
         pick_s = 1'b0;
      end else begin
         pick_s = 1'b1;
      end
   end

   // Next-state and next-register values; acks are combinational from mem_ack_i.
   always_comb begin
      next_state_s = state_r;
      grant_s      = grant_r;
      last_grant_s = last_grant_r;
      wait_cnt_s   = wait_cnt_r;
      err_s        = err_r;
      mem_enable_s = mem_enable_r;
      mem_write_s  = mem_write_r;
      mem_addr_s   = mem_addr_r;
      mem_data_s   = mem_data_r;
      ack0_s       = 1'b0;
      ack1_s       = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.p0_enable_i || bus.p1_enable_i) begin
               next_state_s = BUSY;
               grant_s      = pick_s;
               last_grant_s = pick_s;
               wait_cnt_s   = '0;
               mem_enable_s = 1'b1;
               mem_write_s  = pick_s ? bus.p1_write_i : bus.p0_write_i;
               mem_addr_s   = pick_s ? bus.p1_addr_i  : bus.p0_addr_i;
               mem_data_s   = pick_s ? bus.p1_data_i  : bus.p0_data_i;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            // An ack on the watchdog's final cycle still completes normally.
            if (bus.mem_ack_i) begin
               ack0_s       = ~grant_r;
               ack1_s       = grant_r;
               mem_enable_s = 1'b0;
               next_state_s = DONE;
            end else if (WDOG_EN && (wait_cnt_r == CNT_LAST)) begin
               err_s        = 1'b1;
               mem_enable_s = 1'b0;
               next_state_s = DONE;
            end else begin
               wait_cnt_s   = WDOG_EN ? (wait_cnt_r + CNT_W'(1)) : wait_cnt_r;
               next_state_s = BUSY;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            mem_enable_s = 1'b0;
            next_state_s = IDLE;
         end
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         wait_cnt_r   <= '0;
         err_r        <= 1'b0;
         mem_enable_r <= 1'b0;
         mem_write_r  <= 1'b0;
         mem_addr_r   <= '0;
         mem_data_r   <= '0;
      end else begin
         state_r      <= next_state_s;
         grant_r      <= grant_s;
         last_grant_r <= last_grant_s;
         wait_cnt_r   <= wait_cnt_s;
         err_r        <= err_s;
         mem_enable_r <= mem_enable_s;
         mem_write_r  <= mem_write_s;
         mem_addr_r   <= mem_addr_s;
         mem_data_r   <= mem_data_s;
      end
   end

   assign bus.p0_ack_o     = ack0_s;
   assign bus.p1_ack_o     = ack1_s;
   assign bus.p0_data_o    = ack0_s ? bus.mem_data_i : '0;
   assign bus.p1_data_o    = ack1_s ? bus.mem_data_i : '0;
   assign bus.mem_enable_o = mem_enable_r;
   assign bus.mem_write_o  = mem_write_r;
   assign bus.mem_addr_o   = mem_addr_r;
   assign bus.mem_data_o   = mem_data_r;
   assign bus.err_o        = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: arbitration table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int DW  = 256;
   localparam int AW  = 32;
   localparam int TMO = 8;
   localparam int NV  = 11;

   typedef logic [DW-1:0] line_t;

   typedef struct {
      logic          e0, e1, w0, w1;
      logic [AW-1:0] a0, a1;
      logic [31:0]   d0, d1;
      int            dly;
      logic          exp_p;
      logic          exp_w;
      logic [AW-1:0] exp_a;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) b ();
   mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) c ();

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b)
   );

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut64 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (c)
   );

   vec_t          tbl [NV];
   vec_t          v;
   line_t         pat, exp_d;
   // reference-model state for the randomized run
   int            m_owner, m_age, m_last, pick;
   bit            m_cool, m_err;
   logic          m_w;
   logic [AW-1:0] m_a;
   line_t         m_d;
   bit            e_en, e_a0, e_a1;
   bit            r_act [2];
   logic          r_w [2];
   logic [AW-1:0] r_a [2];
   line_t         r_d [2];
   bit            rs_act;
   int            rs_cnt;

   task automatic chk_b(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
      end
   endtask

   task automatic chk_a(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_l(input string nm, input line_t act, input line_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = AW'($urandom);
      a[4:0] = 5'd0;
      return a;
   endfunction

   function automatic vec_t mk(input logic e0, input logic e1, input logic w0, input logic w1,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1, input int dly,
                               input logic ep, input logic ew, input logic [AW-1:0] ea);
      vec_t r;
      r.e0 = e0; r.e1 = e1; r.w0 = w0; r.w1 = w1; r.a0 = a0; r.a1 = a1;
      r.d0 = d0; r.d1 = d1; r.dly = dly; r.exp_p = ep; r.exp_w = ew; r.exp_a = ea;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      b.p0_enable_i = 1'b0; b.p0_write_i = 1'b0; b.p0_addr_i = '0; b.p0_data_i = '0;
      b.p1_enable_i = 1'b0; b.p1_write_i = 1'b0; b.p1_addr_i = '0; b.p1_data_i = '0;
      b.mem_ack_i   = 1'b0; b.mem_data_i = '0;
      c.p0_enable_i = 1'b0; c.p0_write_i = 1'b0; c.p0_addr_i = '0; c.p0_data_i = '0;
      c.p1_enable_i = 1'b0; c.p1_write_i = 1'b0; c.p1_addr_i = '0; c.p1_data_i = '0;
      c.mem_ack_i   = 1'b0; c.mem_data_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      do_reset();
      rst = 1'b1;
      #1;
      chk_b("rst_en",   b.mem_enable_o, 1'b0);
      chk_b("rst_wr",   b.mem_write_o,  1'b0);
      chk_a("rst_addr", b.mem_addr_o,   '0);
      chk_l("rst_data", b.mem_data_o,   '0);
      chk_b("rst_ack0", b.p0_ack_o,     1'b0);
      chk_b("rst_ack1", b.p1_ack_o,     1'b0);
      chk_b("rst_err",  b.err_o,        1'b0);
      rst = 1'b0;

      // Single read on the default-watchdog instance, memory answers after 10 cycles.
      c.p0_enable_i = 1'b1; c.p0_write_i = 1'b0; c.p0_addr_i = 32'h0000_0400;
      tick();
      @(negedge clk);
      chk_b("rd_en",   c.mem_enable_o, 1'b1);
      chk_a("rd_addr", c.mem_addr_o,   32'h0000_0400);
      chk_b("rd_wr",   c.mem_write_o,  1'b0);
      for (int k = 1; k < 10; k++) begin
         tick();
         @(negedge clk);
         chk_b("rd_wait_ack", c.p0_ack_o | c.p1_ack_o, 1'b0);
         chk_b("rd_wait_en",  c.mem_enable_o, 1'b1);
      end
      tick();
      pat = rand_line();
      c.mem_ack_i = 1'b1; c.mem_data_i = pat;
      @(negedge clk);
      chk_b("rd_ack0",  c.p0_ack_o,  1'b1);
      chk_l("rd_data0", c.p0_data_o, pat);
      chk_b("rd_ack1",  c.p1_ack_o,  1'b0);
      chk_l("rd_data1", c.p1_data_o, '0);
      tick();
      c.mem_ack_i = 1'b0; c.p0_enable_i = 1'b0;
      @(negedge clk);
      chk_b("rd_ack_pulse", c.p0_ack_o,    1'b0);
      chk_l("rd_data_zero", c.p0_data_o,   '0);
      chk_b("rd_en_drop",   c.mem_enable_o, 1'b0);
      chk_b("rd_err",       c.err_o,        1'b0);
      tick();

      // Arbitration table on the TIMEOUT=8 instance; last winner after reset is p1.
      tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h2000, 32'hA0A0_0000, 32'hB0B0_0000, 0, 1'b0, 1'b0, 32'h1000);
      tbl[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h1020, 32'h2020, 32'hA0A0_0001, 32'hB0B0_0001, 2, 1'b1, 1'b0, 32'h2020);
      tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h1040, 32'h2040, 32'hA0A0_0002, 32'hB0B0_0002, 1, 1'b0, 1'b0, 32'h1040);
      tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0800, 32'h2060, 32'hC0DE_0800, 32'hB0B0_0003, 3, 1'b0, 1'b1, 32'h0800);
      tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h0C00, 32'h2080, 32'hA0A0_0004, 32'hB0B0_0004, 0, 1'b0, 1'b0, 32'h0C00);
      tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h1060, 32'h20A0, 32'hA0A0_0005, 32'hB0B0_0005, 4, 1'b1, 1'b1, 32'h20A0);
      tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h1080, 32'h3000, 32'hA0A0_0006, 32'hB0B0_0006, 0, 1'b1, 1'b0, 32'h3000);
      tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h10A0, 32'h3020, 32'hA0A0_0007, 32'hB0B0_0007, 1, 1'b0, 1'b1, 32'h10A0);
      tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h10C0, 32'h3040, 32'hA0A0_0008, 32'hB0B0_0008, 5, 1'b1, 1'b1, 32'h3040);
      tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h10E0, 32'h3060, 32'hA0A0_0009, 32'hB0B0_0009, 0, 1'b0, 1'b0, 32'h10E0);
      tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h1100, 32'h3080, 32'hA0A0_000A, 32'hB0B0_000A, 2, 1'b1, 1'b1, 32'h3080);

      for (int i = 0; i < NV; i++) begin
         v = tbl[i];
         b.p0_enable_i = v.e0; b.p0_write_i = v.w0; b.p0_addr_i = v.a0; b.p0_data_i = {(DW/32){v.d0}};
         b.p1_enable_i = v.e1; b.p1_write_i = v.w1; b.p1_addr_i = v.a1; b.p1_data_i = {(DW/32){v.d1}};
         exp_d = v.exp_p ? {(DW/32){v.d1}} : {(DW/32){v.d0}};
         tick();
         @(negedge clk);
         chk_b("tbl_en",   b.mem_enable_o, 1'b1);
         chk_b("tbl_wr",   b.mem_write_o,  v.exp_w);
         chk_a("tbl_addr", b.mem_addr_o,   v.exp_a);
         chk_l("tbl_data", b.mem_data_o,   exp_d);
         for (int k = 0; k < v.dly; k++) begin
            tick();
            b.p0_write_i = ~b.p0_write_i; b.p0_addr_i = rand_addr(); b.p0_data_i = rand_line();
            b.p1_write_i = ~b.p1_write_i; b.p1_addr_i = rand_addr(); b.p1_data_i = rand_line();
            @(negedge clk);
            chk_b("hold_wr",    b.mem_write_o, v.exp_w);
            chk_a("hold_addr",  b.mem_addr_o,  v.exp_a);
            chk_l("hold_data",  b.mem_data_o,  exp_d);
            chk_b("hold_noack", b.p0_ack_o | b.p1_ack_o, 1'b0);
         end
         tick();
         pat = rand_line();
         b.mem_ack_i = 1'b1; b.mem_data_i = pat;
         @(negedge clk);
         chk_b("tbl_ack_g",  v.exp_p ? b.p1_ack_o  : b.p0_ack_o,  1'b1);
         chk_b("tbl_ack_ng", v.exp_p ? b.p0_ack_o  : b.p1_ack_o,  1'b0);
         chk_l("tbl_rdata",  v.exp_p ? b.p1_data_o : b.p0_data_o, pat);
         chk_l("tbl_zdata",  v.exp_p ? b.p0_data_o : b.p1_data_o, '0);
         tick();
         b.mem_ack_i = 1'b0; b.p0_enable_i = 1'b0; b.p1_enable_i = 1'b0;
         @(negedge clk);
         chk_b("done_en",  b.mem_enable_o, 1'b0);
         chk_b("done_ack", b.p0_ack_o | b.p1_ack_o, 1'b0);
         tick();
      end

      // Watchdog expiry: no ack for 8 busy cycles, then a later request still completes.
      do_reset();
      b.p0_enable_i = 1'b1; b.p0_addr_i = 32'h0000_4000;
      tick();
      for (int k = 1; k <= TMO; k++) begin
         @(negedge clk);
         chk_b("tmo_busy_en",  b.mem_enable_o, 1'b1);
         chk_b("tmo_busy_ack", b.p0_ack_o, 1'b0);
         chk_b("tmo_busy_err", b.err_o, 1'b0);
         tick();
      end
      b.p0_enable_i = 1'b0;
      @(negedge clk);
      chk_b("tmo_en_drop", b.mem_enable_o, 1'b0);
      chk_b("tmo_err_set", b.err_o, 1'b1);
      chk_b("tmo_no_ack",  b.p0_ack_o | b.p1_ack_o, 1'b0);
      tick();
      b.p1_enable_i = 1'b1; b.p1_addr_i = 32'h0000_5000;
      tick();
      @(negedge clk);
      chk_a("tmo_next_addr", b.mem_addr_o, 32'h0000_5000);
      tick();
      b.mem_ack_i = 1'b1; b.mem_data_i = rand_line();
      @(negedge clk);
      chk_b("tmo_next_ack", b.p1_ack_o, 1'b1);
      tick();
      b.mem_ack_i = 1'b0; b.p1_enable_i = 1'b0;
      @(negedge clk);
      chk_b("tmo_err_sticky", b.err_o, 1'b1);
      tick();

      // Ack on the final watchdog cycle wins.
      do_reset();
      chk_b("tmo_err_clr", b.err_o, 1'b0);
      b.p1_enable_i = 1'b1; b.p1_addr_i = 32'h0000_6000;
      tick();
      for (int k = 1; k < TMO; k++) begin
         @(negedge clk);
         chk_b("edge_busy_en", b.mem_enable_o, 1'b1);
         tick();
      end
      pat = rand_line();
      b.mem_ack_i = 1'b1; b.mem_data_i = pat;
      @(negedge clk);
      chk_b("edge_ack1",  b.p1_ack_o,  1'b1);
      chk_l("edge_data1", b.p1_data_o, pat);
      chk_b("edge_ack0",  b.p0_ack_o,  1'b0);
      tick();
      b.mem_ack_i = 1'b0; b.p1_enable_i = 1'b0;
      @(negedge clk);
      chk_b("edge_err", b.err_o, 1'b0);
      chk_b("edge_en",  b.mem_enable_o, 1'b0);
      tick();

      // Reset three cycles into a transfer abandons it immediately.
      b.p0_enable_i = 1'b1; b.p0_write_i = 1'b1; b.p0_addr_i = 32'h0000_7000; b.p0_data_i = rand_line();
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      b.mem_ack_i = 1'b1;
      #1;
      chk_b("mrst_en",   b.mem_enable_o, 1'b0);
      chk_b("mrst_wr",   b.mem_write_o,  1'b0);
      chk_a("mrst_addr", b.mem_addr_o,   '0);
      chk_l("mrst_data", b.mem_data_o,   '0);
      chk_b("mrst_ack",  b.p0_ack_o | b.p1_ack_o, 1'b0);
      tick();
      rst = 1'b0;
      b.mem_ack_i = 1'b0; b.p0_enable_i = 1'b0;
      b.p1_enable_i = 1'b1; b.p1_write_i = 1'b0; b.p1_addr_i = 32'h0000_7100;
      tick();
      @(negedge clk);
      chk_b("mrst_regrant_en",   b.mem_enable_o, 1'b1);
      chk_a("mrst_regrant_addr", b.mem_addr_o, 32'h0000_7100);
      tick();
      b.mem_ack_i = 1'b1; b.mem_data_i = rand_line();
      @(negedge clk);
      chk_b("mrst_ack1", b.p1_ack_o, 1'b1);
      chk_b("mrst_ack0", b.p0_ack_o, 1'b0);
      tick();
      b.mem_ack_i = 1'b0; b.p1_enable_i = 1'b0;

      // Randomized traffic against a transaction-level model.
      do_reset();
      m_owner = -1; m_age = 0; m_last = 1; m_cool = 1'b0; m_err = 1'b0;
      m_w = 1'b0; m_a = '0; m_d = '0;
      r_act[0] = 1'b0; r_act[1] = 1'b0; rs_act = 1'b0; rs_cnt = 0;
      for (int p = 0; p < 2; p++) begin
         r_w[p] = 1'b0; r_a[p] = '0; r_d[p] = '0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!r_act[p]) begin
               if ($urandom_range(0, 2) == 0) begin
                  r_act[p] = 1'b1; r_w[p] = 1'($urandom_range(0, 1)); r_a[p] = rand_addr(); r_d[p] = rand_line();
               end
            end else if ($urandom_range(0, 15) == 0) begin
               r_act[p] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               r_w[p] = 1'($urandom_range(0, 1)); r_a[p] = rand_addr(); r_d[p] = rand_line();
            end
         end
         b.p0_enable_i = r_act[0]; b.p0_write_i = r_w[0]; b.p0_addr_i = r_a[0]; b.p0_data_i = r_d[0];
         b.p1_enable_i = r_act[1]; b.p1_write_i = r_w[1]; b.p1_addr_i = r_a[1]; b.p1_data_i = r_d[1];
         if (b.mem_enable_o) begin
            if (!rs_act) begin
               rs_act = 1'b1;
               rs_cnt = $urandom_range(0, 10);
            end
            b.mem_ack_i = (rs_cnt == 0);
            if (rs_cnt > 0) rs_cnt--;
         end else begin
            rs_act = 1'b0;
            b.mem_ack_i = ($urandom_range(0, 5) == 0);
         end
         b.mem_data_i = rand_line();
         @(negedge clk);
         e_en = (m_owner >= 0);
         e_a0 = (m_owner == 0) && b.mem_ack_i;
         e_a1 = (m_owner == 1) && b.mem_ack_i;
         chk_b("rnd_en",    b.mem_enable_o, e_en);
         chk_b("rnd_wr",    b.mem_write_o,  m_w);
         chk_a("rnd_addr",  b.mem_addr_o,   m_a);
         chk_l("rnd_data",  b.mem_data_o,   m_d);
         chk_b("rnd_ack0",  b.p0_ack_o,     e_a0);
         chk_b("rnd_ack1",  b.p1_ack_o,     e_a1);
         chk_l("rnd_rdat0", b.p0_data_o,    e_a0 ? b.mem_data_i : '0);
         chk_l("rnd_rdat1", b.p1_data_o,    e_a1 ? b.mem_data_i : '0);
         chk_b("rnd_err",   b.err_o,        m_err);
         if (e_a0) r_act[0] = 1'b0;
         if (e_a1) r_act[1] = 1'b0;
         // Advance the model across the coming clock edge.
         if (m_owner >= 0) begin
            if (b.mem_ack_i) begin
               m_owner = -1; m_cool = 1'b1;
            end else if (m_age == TMO - 1) begin
               m_owner = -1; m_cool = 1'b1; m_err = 1'b1;
            end else begin
               m_age++;
            end
         end else if (m_cool) begin
            m_cool = 1'b0;
         end else if (b.p0_enable_i || b.p1_enable_i) begin
            if (b.p0_enable_i && b.p1_enable_i) pick = 1 - m_last;
            else pick = b.p0_enable_i ? 0 : 1;
            m_last = pick; m_owner = pick; m_age = 0;
            m_w = (pick == 1) ? b.p1_write_i : b.p0_write_i;
            m_a = (pick == 1) ? b.p1_addr_i  : b.p0_addr_i;
            m_d = (pick == 1) ? b.p1_data_i  : b.p0_data_i;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
